// File: rtl/shift_left_arbiter.sv
// rtl/shift_left_arbiter.sv - two-requester round-robin arbiter sharing one 16-bit left shifter
//
// Purpose: serialises shift operations from two ALU issue ports onto one
// zero-fill left shifter and holds each result, tagged with its source, in
// a one-entry output register that honours downstream backpressure.
//
// Optional feature macro: SHIFT_LEFT_ARBITER_STATS_EN (per-requester grant
// counters with synchronous clear).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/req0_a/req0_amt      requester 0 operation (operand, shift 0..15)
//   req0_ready                      requester 0 operation accepted this cycle
//   req1_valid/req1_a/req1_amt      requester 1 operation
//   req1_ready                      requester 1 operation accepted this cycle
//   res_valid/res_data/res_src      registered result and its source requester
//   res_ready                       consumer takes the result this cycle
//   stats_clr                       (stats build) zero both grant counters
//   grant_cnt0/grant_cnt1           (stats build) saturating handshake counts
module shift_left_arbiter #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [3:0]  req0_amt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [3:0]  req1_amt,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_src,
  input  logic        res_ready
`ifdef SHIFT_LEFT_ARBITER_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  localparam logic PRIO = RESET_PRIO[0];

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic [15:0] data_q;
  logic        src_q;

  logic        accept_ok;
  logic        grant_any;
  logic        grant_sel;
  logic        handshake;
  logic [15:0] sel_a;
  logic [3:0]  sel_amt;
  logic [15:0] shifted;

  // Arbitration and output-stage next state.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    accept_ok = 1'b0;
    handshake = 1'b0;
    state_d   = state_q;

    if (req0_valid && req1_valid) begin
      grant_any = 1'b1;
      grant_sel = ~last_grant_q;
    end else if (req0_valid) begin
      grant_any = 1'b1;
      grant_sel = 1'b0;
    end else if (req1_valid) begin
      grant_any = 1'b1;
      grant_sel = 1'b1;
    end

    // rst_n gates acceptance so no ready is reported while reset is held,
    // even though the output stage already reads EMPTY.
    accept_ok = rst_n && ((state_q == EMPTY) || res_ready);
    handshake = accept_ok && grant_any;

    if (handshake) begin
      state_d = FULL;
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  assign req0_ready = handshake && (grant_sel == 1'b0);
  assign req1_ready = handshake && (grant_sel == 1'b1);

  // Only the granted operand reaches the shifter; it is sampled on the
  // handshake edge, so res_data has no combinational path from the inputs.
  assign sel_a   = grant_sel ? req1_a   : req0_a;
  assign sel_amt = grant_sel ? req1_amt : req0_amt;
  assign shifted = sel_a << sel_amt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= ~PRIO;
      data_q       <= 16'h0000;
      src_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        data_q       <= shifted;
        src_q        <= grant_sel;
        last_grant_q <= grant_sel;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = data_q;
  assign res_src   = src_q;

`ifdef SHIFT_LEFT_ARBITER_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  // Clear has priority over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else if (stats_clr) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      if (req0_ready && (cnt0_q != 16'hFFFF)) begin
        cnt0_q <= cnt0_q + 16'd1;
      end
      if (req1_ready && (cnt1_q != 16'hFFFF)) begin
        cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/shift_left_arbiter.md
# shift_left_arbiter

- Shares one 16-bit zero-fill left shifter (shift amount 0–15) between two requesters.
- Arbitrates round-robin with valid/ready handshakes.
- Registers the shifted result, tagged with its source, in a one-entry output stage that honours downstream backpressure.
- Sits between the ALU issue logic and the ALU result bus, serialising shift operations from the two issue ports.

## Interface
Parameters:
- RESET_PRIO, default 0: requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_a  in  16  requester 0 operand
- req0_amt  in  4  requester 0 shift amount
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_amt, req1_ready: same as requester 0, for requester 1
- res_valid  out  1  output register holds a result
- res_data  out  16  shifted result
- res_src  out  1  requester that produced res_data
- res_ready  in  1  consumer takes result this cycle

## Operation
- Shift function: res = {a[15-amt:0], amt zeros}.
  - amt=0 passes a unchanged.
  - amt=15 yields {a[0],15'b0}.
  - Bits shifted past bit 15 are discarded; no carry/overflow output.
- Output stage states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- accept_ok = EMPTY, or (FULL and res_ready).
- Grant, combinational:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant = ~last_grant.
  - Neither valid: no grant.
- reqN_ready = accept_ok and grant==N. At most one ready high per cycle.
- ready may depend on valid; valid must not depend on ready (requester side).
- Handshake on requester N (reqN_valid & reqN_ready) at an edge:
  - res_data ← shifted reqN_a, res_src ← N, res_valid ← 1.
  - last_grant ← N.
- FULL, res_ready=1, no handshake: res_valid ← 0 (EMPTY).
- FULL, res_ready=0: res_valid, res_data and res_src hold stable. All reqN_ready=0.
- last_grant updates only on a completed handshake. A pending valid with no accept leaves the priority unchanged.
- Requester inputs are sampled only on the handshake edge.

## Timing
- Reset (rst_n=0, immediate, asynchronous):
  - res_valid=0, res_data=16'h0000, res_src=0.
  - last_grant=~RESET_PRIO, so RESET_PRIO wins the first tie.
  - reqN_ready is 0 while rst_n=0.
  - Deassertion is used synchronously by the surrounding design.
- Latency: handshake at edge k → res_valid=1 with result visible after edge k.
- Throughput: one operation per cycle while res_ready=1 continuously. Drain and refill occur in the same cycle.
- Both requesters continuously valid, res_ready=1: grants alternate every cycle (0,1,0,1… when RESET_PRIO=0).
- Reset mid-operation: a held result is discarded; no handshake is reported to requesters.
- No combinational path from req*_a/req*_amt to res_data (registered).
- Combinational path exists from res_ready and req*_valid to req*_ready.

## Configuration
- SHIFT_LEFT_ARBITER_STATS_EN defined adds:
  - Input stats_clr (1 bit).
  - Outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - Each counter increments on its requester's handshake and saturates at 16'hFFFF.
  - stats_clr=1 synchronously zeroes both counters; clear wins over a same-cycle increment.
  - Counters reset to 0 on rst_n.
- Undefined: no stats ports, no counters; all other behaviour identical.

## Test plan
- Reset: assert rst_n=0 mid-FULL with res_data=16'h1234 → res_valid=0, res_data=16'h0000 immediately. After release, both valid → req0_ready=1 (RESET_PRIO=0).
- Single requester: req0_a=16'h00F1, amt=4, res_ready=1 → next cycle res_valid=1, res_data=16'h0F10, res_src=0.
- Shift bounds: amt=0 on 16'hA5A5 → 16'hA5A5. amt=15 on 16'h0003 → 16'h8000. amt=8 on 16'hFFFF → 16'hFF00.
- Contention: both valid for 6 cycles, res_ready=1 → res_src sequence 0,1,0,1,0,1; exactly one ready high each cycle.
- Backpressure: result FULL, res_ready=0 for 3 cycles with both requesters valid → req0_ready=req1_ready=0 and res_data stable. The cycle res_ready rises, the next grant handshakes and the new result appears on the following edge.
- Stats (SHIFT_LEFT_ARBITER_STATS_EN): 5 grants to req1 → grant_cnt1=5. stats_clr pulsed during a grant → grant_cnt1=0. Preload-saturation test: counter stays 16'hFFFF after a further grant.
